// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU operand/select path among four requesters.
// Latency: request sampled at edge E, response valid at edge E+RESULT_WAIT; RESULT_WAIT+2 cycles per op minimum.
// Backpressure: response held in RESP until rsp_ready; req ignored outside IDLE, pending requests wait.
module alu_arbiter #(
  parameter int WIDTH       = 8,
  parameter int RESULT_WAIT = 1   // legal range 1..15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  input  logic [7:0]         req_op,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Counter is loaded with WAIT-1 so operands stay on the ALU for exactly RESULT_WAIT cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(RESULT_WAIT - 1);

  state_t     state;
  logic [1:0] rr_ptr;
  logic [3:0] wait_cnt;
  logic [1:0] win_id;
  logic       win_vld;

  // Pick the first requester at or after rr_ptr; scan from farthest so the nearest one wins.
  always_comb begin
    win_id  = 2'd0;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) begin
        win_id  = rr_ptr + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  // Sequencing FSM: grant and latch operands, wait for the result, then hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      wait_cnt  <= 4'd0;
      gnt       <= 4'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_data  <= '0;
    end else begin
      gnt <= 4'd0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            alu_a    <= req_a[win_id*WIDTH +: WIDTH];
            alu_b    <= req_b[win_id*WIDTH +: WIDTH];
            alu_sel  <= req_op[win_id*2 +: 2];
            rsp_id   <= win_id;
            gnt      <= 4'b0001 << win_id;
            wait_cnt <= WAIT_LOAD;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (wait_cnt == 4'd0) begin
            rsp_data  <= alu_y;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= rsp_id + 2'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
